time_proportion_mc: RTL and testbench
=====================================

# time_proportion_mc

Multi-channel, parametrised time-proportioning output stage for the heater power path. Each channel converts an unsigned duty value, in clock cycles per window, into a slow on/off TRIGGER within a common, runtime-programmable sampling window. Duty and period are latched only at window boundaries, so outputs never glitch mid-window. Minimum on/off pulse enforcement protects the SSR/relay, and an enable gate forces every output off immediately.

## Interface
- N_CH, 4: number of independent output channels (≥1).
- CNT_W, 25: width of the counter, period and duty values.
- PERIOD_RST, 28_800_901: window length in cycles after reset (≥2).
- MIN_PULSE, 0: minimum on-time and off-time in cycles; 0 disables enforcement.

- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- EN  in  1  run enable; low forces idle with all outputs off.
- PERIOD_IN  in  CNT_W  new window length in cycles.
- PERIOD_LD  in  1  one-cycle strobe that captures PERIOD_IN into the pending-period register.
- VALUE  in  N_CH*CNT_W  per-channel duty in cycles; channel i occupies bits [i*CNT_W +: CNT_W].
- TRIGGER  out  N_CH  per-channel heater drive.
- WINDOW_START  out  1  high during count 0 of every running window.
- RUNNING  out  1  high while the FSM is in RUN.

## Operation
- Registers: state (IDLE/RUN), cnt, period_reg, period_pend, duty[N_CH]. All are unsigned CNT_W, except state.
- Reset values: state=IDLE, cnt=0, period_reg=period_pend=PERIOD_RST, duty=0. TRIGGER=0, WINDOW_START=0, RUNNING=0.
- PERIOD_LD: if PERIOD_IN ≥ 2, period_pend ← PERIOD_IN. Otherwise the strobe is ignored.
- Effective new period: pn = PERIOD_LD&&PERIOD_IN≥2 ? PERIOD_IN : period_pend. A load on the latch edge is applied on that edge.
- Latch event, on IDLE→RUN or on the RUN wrap edge:
  - period_reg ← pn.
  - duty[i] ← clamp(VALUE[i], pn).
  - cnt ← 0.
- clamp(v,p):
  - v ≥ p → p (full on).
  - else v < MIN_PULSE → 0.
  - else p−v < MIN_PULSE → p.
  - else v.
- FSM transitions:
  - IDLE: if EN, do the latch event and go to RUN.
  - RUN:
    - EN=0 → IDLE, cnt ← 0. This is immediate; the window is not completed.
    - Else if cnt = period_reg−1, do the latch event (wrap).
    - Else cnt ← cnt+1.
- Outputs are decoded from registers only. There is no combinational path from VALUE or EN.
  - TRIGGER[i] = RUNNING && (duty[i] > cnt).
  - WINDOW_START = RUNNING && cnt==0.
  - RUNNING = state==RUN.
- VALUE changes mid-window have no effect until the next wrap.

## Timing
- IDLE→RUN: EN sampled high at edge k. RUNNING, WINDOW_START and the first-window TRIGGERs are valid after edge k.
- Window length is exactly period_reg cycles. WINDOW_START pulses every period_reg cycles, one cycle wide.
- A channel with duty d (0<d<p) is high for cycles 0..d−1 of each window.
  - d=0: always low.
  - d=p: continuously high across windows, with no gap at the wrap.
- EN falling sampled at edge k: all TRIGGER, RUNNING and WINDOW_START are 0 after edge k.
- RST_N assertion clears all outputs asynchronously, regardless of clock.
- Comparison and the clamp are unsigned, with no overflow. p−v is computed only when v < p.

## Test plan
- Reset and idle: hold RST_N low, then release with EN=0 for 50 cycles → TRIGGER=0, RUNNING=0, WINDOW_START=0 throughout. Assert RST_N mid-RUN → all outputs 0 without a clock edge.
- Basic duty: PERIOD_LD with PERIOD_IN=10, N_CH=4, VALUE={0,3,10,15}, EN=1 → WINDOW_START every 10 cycles. TRIGGER[0] always 0, TRIGGER[1] high for 3 of 10 cycles, TRIGGER[2] and TRIGGER[3] constantly high.
- Boundary latching: period 10, VALUE[1]=3. Change VALUE[1] to 7 at cycle 4 of a window → the current window still has 3 high cycles; the next window has 7. PERIOD_LD 20 in mid-window → the next window is 20 cycles. PERIOD_LD 1 → ignored.
- Min pulse: MIN_PULSE=3, period 10, VALUE={2,3,8,7} → channel 0 off; channel 1 has 3 high cycles; channel 2 fully on; channel 3 has 7 high cycles.
- Enable drop: period 10, duty 6. Drop EN at cycle 2 → TRIGGER low on the next cycle. Re-raise EN → a new window starts at cnt=0 with WINDOW_START.
- Wrap with simultaneous load: assert PERIOD_LD=16 exactly on the wrap edge → the following window is 16 cycles, and duty is clamped against 16.

Source files
------------

// File: rtl/time_proportion_mc.sv
// Multi-channel time-proportioning output stage for the heater power path.
// A shared window counter runs over a programmable period; each channel turns
// its duty value (cycles per window) into an on/off drive that is high for the
// first duty cycles of every window. Duty and period only change at window
// boundaries, so a drive never glitches mid-window.

// Per-channel slice: clamps the incoming duty against the new period, holds it
// for a whole window and compares it with the shared counter.
module time_proportion_mc_ch #(
    parameter int CNT_W     = 25,
    parameter int MIN_PULSE = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             latch,
    input  logic [CNT_W-1:0] value,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] cnt,
    input  logic             running,
    output logic             trigger
);

    logic [CNT_W-1:0] clamped;
    logic [CNT_W-1:0] duty;

    generate
        if (MIN_PULSE == 0) begin : g_no_min
            // Without pulse enforcement only the full-on saturation applies.
            assign clamped = (value >= period) ? period : value;
        end else begin : g_min
            localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PULSE);
            // Pulses shorter than MIN_P collapse to off; gaps shorter than
            // MIN_P collapse to full on. period - value only when value < period.
            always_comb begin
                clamped = value;
                if (value >= period)
                    clamped = period;
                else if (value < MIN_P)
                    clamped = '0;
                else if ((period - value) < MIN_P)
                    clamped = period;
            end
        end
    endgenerate

    // Duty is only captured on the latch event (start or wrap of a window).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            duty <= '0;
        else if (latch)
            duty <= clamped;
    end

    assign trigger = running && (duty > cnt);

endmodule

module time_proportion_mc #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 25,
    parameter int PERIOD_RST = 28_800_901,
    parameter int MIN_PULSE  = 0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic [CNT_W-1:0]      PERIOD_IN,
    input  logic                  PERIOD_LD,
    input  logic [N_CH*CNT_W-1:0] VALUE,
    output logic [N_CH-1:0]       TRIGGER,
    output logic                  WINDOW_START,
    output logic                  RUNNING
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);
    localparam logic [CNT_W-1:0] PERIOD_MIN  = CNT_W'(2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] period_pend;

    logic             load_ok;
    logic [CNT_W-1:0] pn;
    logic             last;
    logic             latch;
    logic             running;

    // A load on the latch edge takes effect on that same edge.
    assign load_ok = PERIOD_LD && (PERIOD_IN >= PERIOD_MIN);
    assign pn      = load_ok ? PERIOD_IN : period_pend;
    assign last    = (cnt == period_reg - CNT_W'(1));
    assign latch   = EN && ((state == IDLE) || last);
    assign running = (state == RUN);

    // Window FSM: counter, active period and pending period.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cnt         <= '0;
            period_reg  <= PERIOD_INIT;
            period_pend <= PERIOD_INIT;
        end else begin
            if (load_ok)
                period_pend <= PERIOD_IN;
            case (state)
                IDLE: begin
                    if (EN) begin
                        state      <= RUN;
                        cnt        <= '0;
                        period_reg <= pn;
                    end
                end
                RUN: begin
                    if (!EN) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (last) begin
                        cnt        <= '0;
                        period_reg <= pn;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            time_proportion_mc_ch #(
                .CNT_W    (CNT_W),
                .MIN_PULSE(MIN_PULSE)
            ) u_ch (
                .CLK    (CLK),
                .RST_N  (RST_N),
                .latch  (latch),
                .value  (VALUE[i*CNT_W +: CNT_W]),
                .period (pn),
                .cnt    (cnt),
                .running(running),
                .trigger(TRIGGER[i])
            );
        end
    endgenerate

    assign RUNNING      = running;
    assign WINDOW_START = running && (cnt == '0);

endmodule

// File: tb/tb_time_proportion_mc.sv
// Directed bench for time_proportion_mc: one instance without pulse
// enforcement, a second with MIN_PULSE=3 sharing the same stimulus.
module tb_time_proportion_mc;

    localparam int NC = 4;
    localparam int CW = 25;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            EN;
    logic [CW-1:0]   PERIOD_IN;
    logic            PERIOD_LD;
    logic [NC*CW-1:0] VALUE;
    logic [NC-1:0]   TRIGGER, TRIGGER2;
    logic            WINDOW_START, WS2, RUNNING, RUN2;

    int total = 0;
    int bad   = 0;
    int win_len;
    int ones[NC];

    time_proportion_mc #(.N_CH(NC), .CNT_W(CW), .MIN_PULSE(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .PERIOD_IN(PERIOD_IN),
        .PERIOD_LD(PERIOD_LD), .VALUE(VALUE), .TRIGGER(TRIGGER),
        .WINDOW_START(WINDOW_START), .RUNNING(RUNNING)
    );

    time_proportion_mc #(.N_CH(NC), .CNT_W(CW), .MIN_PULSE(3)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .PERIOD_IN(PERIOD_IN),
        .PERIOD_LD(PERIOD_LD), .VALUE(VALUE), .TRIGGER(TRIGGER2),
        .WINDOW_START(WS2), .RUNNING(RUN2)
    );

    always #5 CLK = ~CLK;

    function automatic logic [NC*CW-1:0] pack4(input int v0, input int v1,
                                               input int v2, input int v3);
        pack4 = {CW'(v3), CW'(v2), CW'(v1), CW'(v0)};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Steps at least once, then until the next WINDOW_START (bounded).
    task automatic wait_ws();
        int n = 0;
        do begin
            step();
            n++;
        end while (!WINDOW_START && n < 200);
        total++;
        if (WINDOW_START !== 1'b1) begin
            bad++;
            $display("FAIL wait_ws: WINDOW_START=%b after %0d cycles, need 1", WINDOW_START, n);
        end
    endtask

    // Starting at a WINDOW_START sample, walk one window, counting its length
    // and per-channel high cycles; optionally strobe a period load or change
    // VALUE at a given cycle index of the window.
    task automatic measure_window(input int ld_at, input logic [CW-1:0] ld_val,
                                  input int v_at, input logic [NC*CW-1:0] v_new);
        win_len = 0;
        for (int c = 0; c < NC; c++) ones[c] = 0;
        do begin
            for (int c = 0; c < NC; c++) if (TRIGGER[c]) ones[c]++;
            if (win_len == ld_at) begin
                PERIOD_LD = 1'b1;
                PERIOD_IN = ld_val;
            end
            if (win_len == v_at) VALUE = v_new;
            step();
            PERIOD_LD = 1'b0;
            win_len++;
        end while (!WINDOW_START && win_len < 200);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; EN = 1'b0; PERIOD_LD = 1'b0; PERIOD_IN = '0;
        VALUE = pack4(5, 5, 5, 5);
        #2;
        total++;
        if ({TRIGGER, WINDOW_START, RUNNING} !== '0) begin
            bad++;
            $display("FAIL reset_hold: outs=%b need 0", {TRIGGER, WINDOW_START, RUNNING});
        end
        repeat (3) step();
        RST_N = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            total++;
            if ({TRIGGER, WINDOW_START, RUNNING, TRIGGER2, WS2, RUN2} !== '0) begin
                bad++;
                $display("FAIL idle_cycle%0d: outs=%b need 0", i,
                         {TRIGGER, WINDOW_START, RUNNING, TRIGGER2, WS2, RUN2});
            end
        end
    endtask

    task automatic test_basic_duty();
        int ws_n = 0, ws_bad = 0, pat_bad = 0;
        int o[NC];
        for (int c = 0; c < NC; c++) o[c] = 0;
        PERIOD_LD = 1'b1; PERIOD_IN = CW'(10);
        step();
        PERIOD_LD = 1'b0;
        VALUE = pack4(0, 3, 10, 15);
        EN = 1'b1;
        step();
        total++;
        if ({RUNNING, WINDOW_START, TRIGGER} !== 6'b11_1110) begin
            bad++;
            $display("FAIL basic_first: run,ws,trig=%b need 111110", {RUNNING, WINDOW_START, TRIGGER});
        end
        for (int i = 0; i < 30; i++) begin
            if (WINDOW_START) begin
                ws_n++;
                if (i % 10 != 0) ws_bad++;
            end
            if (TRIGGER[1] !== ((i % 10) < 3)) pat_bad++;
            for (int c = 0; c < NC; c++) if (TRIGGER[c]) o[c]++;
            step();
        end
        total++;
        if (ws_n != 3 || ws_bad != 0) begin
            bad++;
            $display("FAIL basic_ws: count=%0d misplaced=%0d need 3/0", ws_n, ws_bad);
        end
        total++;
        if (o[0] != 0 || o[1] != 9 || o[2] != 30 || o[3] != 30) begin
            bad++;
            $display("FAIL basic_ones: got %0d %0d %0d %0d need 0 9 30 30", o[0], o[1], o[2], o[3]);
        end
        total++;
        if (pat_bad != 0) begin
            bad++;
            $display("FAIL basic_pattern: ch1 wrong on %0d cycles need 0", pat_bad);
        end
    endtask

    task automatic test_boundary();
        wait_ws();
        measure_window(-1, '0, 4, pack4(0, 7, 10, 15));
        total++;
        if (win_len != 10 || ones[1] != 3) begin
            bad++;
            $display("FAIL bnd_cur_window: len=%0d ch1=%0d need 10/3", win_len, ones[1]);
        end
        measure_window(-1, '0, -1, VALUE);
        total++;
        if (win_len != 10 || ones[1] != 7) begin
            bad++;
            $display("FAIL bnd_next_window: len=%0d ch1=%0d need 10/7", win_len, ones[1]);
        end
        measure_window(3, CW'(20), -1, VALUE);
        total++;
        if (win_len != 10) begin
            bad++;
            $display("FAIL bnd_ld_mid: len=%0d need 10", win_len);
        end
        measure_window(5, CW'(1), -1, VALUE);
        total++;
        if (win_len != 20 || ones[1] != 7) begin
            bad++;
            $display("FAIL bnd_new_period: len=%0d ch1=%0d need 20/7", win_len, ones[1]);
        end
        measure_window(-1, '0, -1, VALUE);
        total++;
        if (win_len != 20 || ones[2] != 10 || ones[3] != 15) begin
            bad++;
            $display("FAIL bnd_ld1_ignored: len=%0d ch2=%0d ch3=%0d need 20/10/15",
                     win_len, ones[2], ones[3]);
        end
    endtask

    task automatic test_wrap_load();
        VALUE = pack4(0, 3, 10, 20);
        measure_window(19, CW'(16), -1, VALUE);
        total++;
        if (win_len != 20 || ones[3] != 15 || ones[1] != 7) begin
            bad++;
            $display("FAIL wrap_old: len=%0d ch1=%0d ch3=%0d need 20/7/15", win_len, ones[1], ones[3]);
        end
        measure_window(-1, '0, -1, VALUE);
        total++;
        if (win_len != 16 || ones[1] != 3 || ones[2] != 10 || ones[3] != 16) begin
            bad++;
            $display("FAIL wrap_new: len=%0d ch1=%0d ch2=%0d ch3=%0d need 16/3/10/16",
                     win_len, ones[1], ones[2], ones[3]);
        end
        measure_window(-1, '0, -1, VALUE);
        total++;
        if (win_len != 16 || ones[3] != 16) begin
            bad++;
            $display("FAIL wrap_full_on: len=%0d ch3=%0d need 16/16", win_len, ones[3]);
        end
    endtask

    task automatic test_min_pulse();
        int ws_n = 0;
        int o[NC];
        for (int c = 0; c < NC; c++) o[c] = 0;
        EN = 1'b0;
        step();
        PERIOD_LD = 1'b1; PERIOD_IN = CW'(10);
        step();
        PERIOD_LD = 1'b0;
        VALUE = pack4(2, 3, 8, 7);
        EN = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            if (WS2) ws_n++;
            for (int c = 0; c < NC; c++) if (TRIGGER2[c]) o[c]++;
            step();
        end
        total++;
        if (ws_n != 2) begin
            bad++;
            $display("FAIL minp_ws: count=%0d need 2", ws_n);
        end
        total++;
        if (o[0] != 0 || o[1] != 6 || o[2] != 20 || o[3] != 14) begin
            bad++;
            $display("FAIL minp_ones: got %0d %0d %0d %0d need 0 6 20 14", o[0], o[1], o[2], o[3]);
        end
    endtask

    task automatic test_enable_drop();
        VALUE = pack4(0, 6, 0, 0);
        wait_ws();
        step();
        step();
        total++;
        if (TRIGGER[1] !== 1'b1) begin
            bad++;
            $display("FAIL en_before: trig1=%b need 1", TRIGGER[1]);
        end
        EN = 1'b0;
        step();
        total++;
        if ({TRIGGER, WINDOW_START, RUNNING} !== '0) begin
            bad++;
            $display("FAIL en_drop: outs=%b need 0", {TRIGGER, WINDOW_START, RUNNING});
        end
        step();
        EN = 1'b1;
        step();
        total++;
        if ({RUNNING, WINDOW_START, TRIGGER[1]} !== 3'b111) begin
            bad++;
            $display("FAIL en_restart: run,ws,trig1=%b need 111", {RUNNING, WINDOW_START, TRIGGER[1]});
        end
        measure_window(-1, '0, -1, VALUE);
        total++;
        if (win_len != 10 || ones[1] != 6) begin
            bad++;
            $display("FAIL en_window: len=%0d ch1=%0d need 10/6", win_len, ones[1]);
        end
    endtask

    task automatic test_async_reset();
        wait_ws();
        #3;
        RST_N = 1'b0;
        #1;
        total++;
        if ({TRIGGER, WINDOW_START, RUNNING, TRIGGER2, WS2, RUN2} !== '0) begin
            bad++;
            $display("FAIL async_reset: outs=%b need 0",
                     {TRIGGER, WINDOW_START, RUNNING, TRIGGER2, WS2, RUN2});
        end
        EN = 1'b0;
        step();
        RST_N = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_duty();
        test_boundary();
        test_wrap_load();
        test_min_pulse();
        test_enable_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
